// File: rtl/radix2_butterfly_pipe_if.sv
// Stream bundle for the radix-2 butterfly: sample-pair input side,
// result output side and the sticky overflow flag with its clear.
interface radix2_butterfly_pipe_if #(
    parameter int DW = 16,
    parameter int TW = 16
);

    logic            in_valid;
    logic [2*DW-1:0] a_in;
    logic [2*DW-1:0] b_in;
    logic [2*TW-1:0] w_in;
    logic            inverse;
    logic            scale;
    logic            ovf_clr;

    logic            out_valid;
    logic [2*DW-1:0] a_out;
    logic [2*DW-1:0] b_out;
    logic            ovf_flag;

    modport master (
        output in_valid, a_in, b_in, w_in,
        output inverse, scale, ovf_clr,
        input  out_valid, a_out, b_out, ovf_flag
    );

    modport slave (
        input  in_valid, a_in, b_in, w_in,
        input  inverse, scale, ovf_clr,
        output out_valid, a_out, b_out, ovf_flag
    );

endinterface

// File: rtl/radix2_butterfly_pipe.sv
// Pipelined radix-2 DIT butterfly: a_out = a + b*w, b_out = a - b*w,
// with conj(w) for the inverse transform, optional /2 and saturation.
module radix2_butterfly_pipe #(
    parameter int DW = 16,
    parameter int TW = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    radix2_butterfly_pipe_if.slave bus
);

    localparam int PW = DW + TW;
    localparam int RW = DW + 2;
    localparam int SW = DW + 3;

    localparam logic signed [TW-1:0] W_MIN = {1'b1, {(TW-1){1'b0}}};
    localparam logic signed [TW-1:0] W_MAX = {1'b0, {(TW-1){1'b1}}};
    localparam logic signed [PW:0]   RND   = (PW+1)'(1) <<< (TW-2);
    localparam logic signed [SW-1:0] O_MAX = {4'b0000, {(DW-1){1'b1}}};
    localparam logic signed [SW-1:0] O_MIN = {4'b1111, {(DW-1){1'b0}}};
    localparam logic signed [SW-1:0] S_ONE = {{(SW-1){1'b0}}, 1'b1};

    // rank 1: registered inputs, twiddle conjugated when inverse
    logic                 v1_q, v1_d;
    logic [2*DW-1:0]      a1_q, a1_d;
    logic signed [DW-1:0] br1_q, br1_d, bi1_q, bi1_d;
    logic signed [TW-1:0] wr1_q, wr1_d, wi1_q, wi1_d;
    logic signed [TW-1:0] wi_in;
    logic                 sc1_q, sc1_d;

    always_comb begin
        v1_d  = bus.in_valid;
        a1_d  = a1_q;
        br1_d = br1_q;
        bi1_d = bi1_q;
        wr1_d = wr1_q;
        wi1_d = wi1_q;
        sc1_d = sc1_q;
        wi_in = bus.w_in[TW-1:0];
        if (bus.in_valid) begin
            a1_d  = bus.a_in;
            br1_d = bus.b_in[2*DW-1:DW];
            bi1_d = bus.b_in[DW-1:0];
            wr1_d = bus.w_in[2*TW-1:TW];
            sc1_d = bus.scale;
            if (!bus.inverse) begin
                wi1_d = wi_in;
            end else if (wi_in == W_MIN) begin
                wi1_d = W_MAX;
            end else begin
                wi1_d = -wi_in;
            end
        end
    end

    // rank 2: partial products
    logic                 v2_q, v2_d;
    logic [2*DW-1:0]      a2_q, a2_d;
    logic                 sc2_q, sc2_d;
    logic signed [PW-1:0] rr2_q, rr2_d, ii2_q, ii2_d;
    logic signed [PW-1:0] ri2_q, ri2_d, ir2_q, ir2_d;

    always_comb begin
        v2_d  = v1_q;
        a2_d  = a2_q;
        sc2_d = sc2_q;
        rr2_d = rr2_q;
        ii2_d = ii2_q;
        ri2_d = ri2_q;
        ir2_d = ir2_q;
        if (v1_q) begin
            a2_d  = a1_q;
            sc2_d = sc1_q;
            rr2_d = PW'(br1_q) * PW'(wr1_q);
            ii2_d = PW'(bi1_q) * PW'(wi1_q);
            ri2_d = PW'(br1_q) * PW'(wi1_q);
            ir2_d = PW'(bi1_q) * PW'(wr1_q);
        end
    end

    // rank 3: complex product rounded back to data scale
    logic                 v3_q, v3_d;
    logic [2*DW-1:0]      a3_q, a3_d;
    logic                 sc3_q, sc3_d;
    logic signed [PW:0]   pr_full, pi_full;
    logic signed [RW-1:0] pr3_q, pr3_d, pi3_q, pi3_d;

    always_comb begin
        v3_d    = v2_q;
        a3_d    = a3_q;
        sc3_d   = sc3_q;
        pr3_d   = pr3_q;
        pi3_d   = pi3_q;
        pr_full = (PW+1)'(rr2_q) - (PW+1)'(ii2_q) + RND;
        pi_full = (PW+1)'(ri2_q) + (PW+1)'(ir2_q) + RND;
        if (v2_q) begin
            a3_d  = a2_q;
            sc3_d = sc2_q;
            pr3_d = RW'(pr_full >>> (TW-1));
            pi3_d = RW'(pi_full >>> (TW-1));
        end
    end

    // rank 4: sum and difference, halved with round-half-up when scaling
    logic                 v4_q, v4_d;
    logic signed [DW-1:0] ar3, ai3;
    logic signed [SW-1:0] sr_raw, si_raw, dr_raw, di_raw;
    logic signed [SW-1:0] sr4_q, sr4_d, si4_q, si4_d;
    logic signed [SW-1:0] dr4_q, dr4_d, di4_q, di4_d;

    function automatic logic signed [SW-1:0] half(
        input logic signed [SW-1:0] x,
        input logic                 en
    );
        half = en ? ((x + S_ONE) >>> 1) : x;
    endfunction

    always_comb begin
        v4_d   = v3_q;
        sr4_d  = sr4_q;
        si4_d  = si4_q;
        dr4_d  = dr4_q;
        di4_d  = di4_q;
        ar3    = a3_q[2*DW-1:DW];
        ai3    = a3_q[DW-1:0];
        sr_raw = SW'(ar3) + SW'(pr3_q);
        si_raw = SW'(ai3) + SW'(pi3_q);
        dr_raw = SW'(ar3) - SW'(pr3_q);
        di_raw = SW'(ai3) - SW'(pi3_q);
        if (v3_q) begin
            sr4_d = half(sr_raw, sc3_q);
            si4_d = half(si_raw, sc3_q);
            dr4_d = half(dr_raw, sc3_q);
            di4_d = half(di_raw, sc3_q);
        end
    end

    // rank 5: saturated outputs and sticky overflow (set beats clear)
    logic            out_valid_q, out_valid_d;
    logic [2*DW-1:0] a_out_q, a_out_d, b_out_q, b_out_d;
    logic            ovf_q, ovf_d;
    logic [DW:0]     s_re, s_im, d_re, d_im;
    logic            any_sat;

    function automatic logic [DW:0] sat(input logic signed [SW-1:0] x);
        if (x > O_MAX) begin
            sat = {1'b1, O_MAX[DW-1:0]};
        end else if (x < O_MIN) begin
            sat = {1'b1, O_MIN[DW-1:0]};
        end else begin
            sat = {1'b0, x[DW-1:0]};
        end
    endfunction

    always_comb begin
        s_re        = sat(sr4_q);
        s_im        = sat(si4_q);
        d_re        = sat(dr4_q);
        d_im        = sat(di4_q);
        any_sat     = s_re[DW] | s_im[DW] | d_re[DW] | d_im[DW];
        out_valid_d = v4_q;
        a_out_d     = a_out_q;
        b_out_d     = b_out_q;
        ovf_d       = ovf_q;
        if (v4_q) begin
            a_out_d = {s_re[DW-1:0], s_im[DW-1:0]};
            b_out_d = {d_re[DW-1:0], d_im[DW-1:0]};
        end
        if (v4_q && any_sat) begin
            ovf_d = 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            a1_q        <= '0;
            br1_q       <= '0;
            bi1_q       <= '0;
            wr1_q       <= '0;
            wi1_q       <= '0;
            sc1_q       <= 1'b0;
            v2_q        <= 1'b0;
            a2_q        <= '0;
            sc2_q       <= 1'b0;
            rr2_q       <= '0;
            ii2_q       <= '0;
            ri2_q       <= '0;
            ir2_q       <= '0;
            v3_q        <= 1'b0;
            a3_q        <= '0;
            sc3_q       <= 1'b0;
            pr3_q       <= '0;
            pi3_q       <= '0;
            v4_q        <= 1'b0;
            sr4_q       <= '0;
            si4_q       <= '0;
            dr4_q       <= '0;
            di4_q       <= '0;
            out_valid_q <= 1'b0;
            a_out_q     <= '0;
            b_out_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            v1_q        <= v1_d;
            a1_q        <= a1_d;
            br1_q       <= br1_d;
            bi1_q       <= bi1_d;
            wr1_q       <= wr1_d;
            wi1_q       <= wi1_d;
            sc1_q       <= sc1_d;
            v2_q        <= v2_d;
            a2_q        <= a2_d;
            sc2_q       <= sc2_d;
            rr2_q       <= rr2_d;
            ii2_q       <= ii2_d;
            ri2_q       <= ri2_d;
            ir2_q       <= ir2_d;
            v3_q        <= v3_d;
            a3_q        <= a3_d;
            sc3_q       <= sc3_d;
            pr3_q       <= pr3_d;
            pi3_q       <= pi3_d;
            v4_q        <= v4_d;
            sr4_q       <= sr4_d;
            si4_q       <= si4_d;
            dr4_q       <= dr4_d;
            di4_q       <= di4_d;
            out_valid_q <= out_valid_d;
            a_out_q     <= a_out_d;
            b_out_q     <= b_out_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.a_out     = a_out_q;
    assign bus.b_out     = b_out_q;
    assign bus.ovf_flag  = ovf_q;

endmodule
